fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that lets NREQ independent producers share the single write port of one `fifo` instance. Each cycle it picks one requester, forwards that requester's byte to the FIFO's `buf_in`/`wt_en`, and returns a registered one-hot grant. It tracks FIFO occupancy, including the write still in flight, so it never writes into a full buffer. It sits directly between the producer blocks and the FIFO write side.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DW`, 8: data width, equal to the FIFO data width.
- `DEPTH`, 64: FIFO capacity in entries.
- `BURST_LEN`, 4: maximum beats per grant, 1..15. Used only when `FIFO_ARB_BURST_EN` is defined.
- `CW`, derived as `$clog2(DEPTH)+1`: occupancy width.
- Ports:
  - `clk`  in  1  Single clock, rising edge.
  - `rst_n`  in  1  Reset, asynchronous, active-low.
  - `req`  in  NREQ  Per-requester write request.
  - `req_data`  in  NREQ*DW  Requester i's data is in slice [i*DW +: DW].
  - `gnt`  out  NREQ  One-hot, registered; the beat was accepted at the preceding edge.
  - `fifo_count`  in  CW  FIFO occupancy.
  - `fifo_wt_en`  out  1  Registered FIFO write enable.
  - `fifo_buf_in`  out  DW  Registered FIFO write data.
  - `src_id`  out  $clog2(NREQ)  Index of the granted requester; valid when `fifo_wt_en` is 1.

## Operation
- **Free space:** free = DEPTH − `fifo_count` − `fifo_wt_en`. The arbiter issues a grant only when free ≥ 1. Width is CW+1 bits; the result is never negative by construction.
- **Round-robin pointer:** `ptr` has reset value 0. The winner is the first `req` bit set, searching from `ptr` upward with wrap-around.
- **Pointer update:** after a single-beat grant, `ptr` = winner+1 mod NREQ. It is unchanged in cycles with no grant.
- **Grant edge:** on the grant edge the block registers:
  - `gnt` = onehot(winner)
  - `fifo_wt_en` = 1
  - `fifo_buf_in` = `req_data` of the winner
  - `src_id` = winner
- **No grant** (no request, or free = 0): `gnt` = 0, `fifo_wt_en` = 0. `fifo_buf_in` and `src_id` hold their previous values.
- **Producer handshake:**
  - A producer holds `req` and its data stable until it sees its `gnt` bit.
  - In the `gnt` cycle the producer either presents its next beat with `req` still high, or deasserts `req`.
  - Each `gnt` pulse corresponds to exactly one FIFO write.
- **Simultaneous events:**
  - All requesters asserting: strict rotation.
  - A requester dropping `req` before it is granted is legal; no beat is taken from it.
- **State machine:** IDLE and LOCK. LOCK exists only when the burst macro is defined; without it the block stays in IDLE and re-arbitrates every cycle.
- **Reset:** `gnt`, `fifo_wt_en`, `fifo_buf_in`, `src_id`, `ptr` and `beat_cnt` all clear to 0, and state returns to IDLE.
- **Reset mid-operation:** assertion clears all outputs asynchronously. A beat whose edge was not reached is dropped, and no partial write occurs.

## Timing
- Latency is 1 cycle from request to grant and to `fifo_wt_en`.
- Throughput is 1 beat per cycle while free ≥ 1.
- Full boundary: with `fifo_count` = DEPTH−1 and `fifo_wt_en` = 1, free = 0, so no grant is issued and no overflow is possible.
- Empty FIFO with no requests: outputs stay idle, with no spurious writes.
- All outputs are driven directly from flops; there is no combinational path from `req` to `gnt`.

## Configuration
- **`FIFO_ARB_BURST_EN` defined:**
  - A grant from IDLE enters LOCK with owner = winner and `beat_cnt` = 1.
  - While in LOCK, the owner is re-granted each cycle while its `req` = 1, free ≥ 1 and `beat_cnt` < BURST_LEN.
  - LOCK is released to IDLE in two cases:
    - `beat_cnt` reaches BURST_LEN, or the owner's `req` = 0: `ptr` = owner+1 mod NREQ, and arbitration resumes in the release cycle.
    - free = 0: the block stalls in LOCK and keeps ownership.
- **`FIFO_ARB_BURST_EN` undefined:** single-beat round-robin, with no LOCK state and no `beat_cnt`.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state enum `arb_state_t` {IDLE, LOCK}
  - default constants `ARB_NREQ`, `ARB_DW`, `ARB_DEPTH`, `ARB_BURST_LEN`
  - the function computing the width of `src_id`
- Sub-module `rr_pick` is a purely combinational rotate/priority-encode/rotate-back. Inputs are `req` and `ptr`; outputs are `winner` and `any`.
- The top level holds the state register, pointer, beat counter, free-space calculation and output registers.

## Test plan
All scenarios use NREQ=4, DW=8, DEPTH=64.
1. Reset: assert `rst_n`=0 mid-cycle → `gnt`=0, `fifo_wt_en`=0, `fifo_buf_in`=8'h00, `src_id`=0 immediately. First grant after release with `req`=4'b1111 → `gnt`=4'b0001.
2. `req`=4'b1111 held, `fifo_count`=0, macro off → `gnt` sequence 0001, 0010, 0100, 1000, 0001, with `src_id` 0,1,2,3,0.
3. Only `req[2]`=1 with data 8'hA5 → next cycle `gnt`=4'b0100, `fifo_wt_en`=1, `fifo_buf_in`=8'hA5, `src_id`=2. `req` dropped → `fifo_wt_en`=0.
4. Full boundary:
   - `fifo_count`=63 and `fifo_wt_en`=1 → no grant.
   - `fifo_count`=63 and `fifo_wt_en`=0 → exactly one grant, then stall.
   - `fifo_count`=64 → zero grants for 10 cycles.
5. Macro on, BURST_LEN=4, `req`=4'b0011 held → `gnt` 0001 ×4 then 0010 ×4. If `fifo_count` goes to 64 mid-burst, the owner is kept and the burst resumes once `fifo_count` < 64.
6. Reset asserted in LOCK after 2 beats → outputs clear at once. After release, state is IDLE, `ptr`=0, and `req`=4'b0010 → `gnt`=4'b0010.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int ARB_NREQ      = 4;
    localparam int ARB_DW        = 8;
    localparam int ARB_DEPTH     = 64;
    localparam int ARB_BURST_LEN = 4;

    function automatic int src_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate req by ptr, take lowest set bit, rotate index back.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = ARB_NREQ
) (
    input  logic [NREQ-1:0]             req,
    input  logic [src_id_w(NREQ)-1:0]   ptr,
    output logic [src_id_w(NREQ)-1:0]   winner,
    output logic                        any
);
    localparam int SW = src_id_w(NREQ);

    logic [NREQ-1:0] rot;
    logic [SW-1:0]   off;
    logic [SW:0]     sum;

    always_comb begin
        rot = NREQ'({req, req} >> ptr);
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SW'(i);
        end
        sum = {1'b0, off} + {1'b0, ptr};
        if (sum >= (SW+1)'(NREQ)) sum = sum - (SW+1)'(NREQ);
        winner = sum[SW-1:0];
        any    = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// Define FIFO_ARB_BURST_EN to let a winner hold the port for up to BURST_LEN beats.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = ARB_NREQ,
    parameter int DW        = ARB_DW,
    parameter int DEPTH     = ARB_DEPTH,
    parameter int BURST_LEN = ARB_BURST_LEN,
    parameter int CW        = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*DW-1:0]          req_data,
    output logic [NREQ-1:0]             gnt,
    input  logic [CW-1:0]               fifo_count,
    output logic                        fifo_wt_en,
    output logic [DW-1:0]               fifo_buf_in,
    output logic [src_id_w(NREQ)-1:0]   src_id
);
    localparam int SW = src_id_w(NREQ);
    localparam int FW = CW + 1;

    if (NREQ < 2 || NREQ > 8 || BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_cfg
        $error("fifo_wr_arbiter: NREQ must be 2..8 and BURST_LEN 1..15");
    end

    function automatic logic [SW-1:0] ptr_inc(input logic [SW-1:0] p);
        return (p == SW'(NREQ - 1)) ? '0 : p + 1'b1;
    endfunction

    arb_state_t                state_q, state_d;
    logic [NREQ-1:0]           gnt_q, gnt_d;
    logic                      fifo_wt_en_q, fifo_wt_en_d;
    logic [DW-1:0]             fifo_buf_in_q, fifo_buf_in_d;
    logic [SW-1:0]             src_id_q, src_id_d;
    logic [SW-1:0]             ptr_q, ptr_d;

    logic [NREQ-1:0][DW-1:0]   data_arr;
    logic [FW-1:0]             free;
    logic                      has_space;
    logic [SW-1:0]             pick_ptr;
    logic [SW-1:0]             winner;
    logic                      any;
    logic                      do_grant;
    logic [SW-1:0]             grant_idx;

    assign data_arr  = req_data;
    // The write registered last edge is not yet reflected in fifo_count.
    assign free      = FW'(DEPTH) - FW'(fifo_count) - FW'(fifo_wt_en_q);
    assign has_space = (free != '0);

`ifdef FIFO_ARB_BURST_EN
    logic [SW-1:0] owner_q, owner_d;
    logic [3:0]    beat_cnt_q, beat_cnt_d;
    logic          release_c;

    assign release_c = (state_q == LOCK) &&
                       ((beat_cnt_q >= 4'(BURST_LEN)) || !req[owner_q]);
    // On release, arbitration restarts just past the old owner in the same cycle.
    assign pick_ptr  = release_c ? ptr_inc(owner_q) : ptr_q;
`else
    assign pick_ptr  = ptr_q;
`endif

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        do_grant      = 1'b0;
        grant_idx     = winner;
        gnt_d         = '0;
        fifo_wt_en_d  = 1'b0;
        fifo_buf_in_d = fifo_buf_in_q;
        src_id_d      = src_id_q;
`ifdef FIFO_ARB_BURST_EN
        owner_d       = owner_q;
        beat_cnt_d    = beat_cnt_q;
        if (state_q == IDLE || release_c) begin
            if (release_c) ptr_d = pick_ptr;
            if (any && has_space) begin
                do_grant   = 1'b1;
                state_d    = LOCK;
                owner_d    = winner;
                beat_cnt_d = 4'd1;
            end else begin
                state_d    = IDLE;
                beat_cnt_d = 4'd0;
            end
        end else if (has_space) begin
            do_grant   = 1'b1;
            grant_idx  = owner_q;
            beat_cnt_d = beat_cnt_q + 4'd1;
        end
`else
        if (any && has_space) begin
            do_grant = 1'b1;
            ptr_d    = ptr_inc(winner);
        end
`endif
        if (do_grant) begin
            gnt_d[grant_idx] = 1'b1;
            fifo_wt_en_d     = 1'b1;
            fifo_buf_in_d    = data_arr[grant_idx];
            src_id_d         = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            gnt_q         <= '0;
            fifo_wt_en_q  <= 1'b0;
            fifo_buf_in_q <= '0;
            src_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            fifo_wt_en_q  <= fifo_wt_en_d;
            fifo_buf_in_q <= fifo_buf_in_d;
            src_id_q      <= src_id_d;
        end
    end

`ifdef FIFO_ARB_BURST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
`endif

    assign gnt         = gnt_q;
    assign fifo_wt_en  = fifo_wt_en_q;
    assign fifo_buf_in = fifo_buf_in_q;
    assign src_id      = src_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DW=8, DEPTH=64, BURST_LEN=4).
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  gnt;
    logic [6:0]  fifo_count = '0;
    logic        fifo_wt_en;
    logic [7:0]  fifo_buf_in;
    logic [1:0]  src_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(4), .DW(8), .DEPTH(64), .BURST_LEN(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .fifo_count  (fifo_count),
        .fifo_wt_en  (fifo_wt_en),
        .fifo_buf_in (fifo_buf_in),
        .src_id      (src_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic w,
                           input logic [7:0] d, input logic [1:0] s);
        chk({tag, " gnt"},    32'(gnt),         32'(g));
        chk({tag, " wt_en"},  32'(fifo_wt_en),  32'(w));
        chk({tag, " buf_in"}, 32'(fifo_buf_in), 32'(d));
        chk({tag, " src_id"}, 32'(src_id),      32'(s));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " gnt"},   32'(gnt),        32'(4'b0000));
        chk({tag, " wt_en"}, 32'(fifo_wt_en), 32'(1'b0));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        #1;
        chk_out("reset_state", 4'b0000, 1'b0, 8'h00, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Leave outputs non-zero, then reset mid-cycle.
        req = 4'b1111;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("midcycle_reset", 4'b0000, 1'b0, 8'h00, 2'd0);
        rst_n = 1'b1;

        tick();
        chk_out("first_grant", 4'b0001, 1'b1, 8'h11, 2'd0);

`ifdef FIFO_ARB_BURST_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("burst0_beat%0d", i + 2), 4'b0001, 1'b1, 8'h11, 2'd0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("burst1_beat%0d", i + 1), 4'b0010, 1'b1, 8'h22, 2'd1);
        end
        req = 4'b0000;
        tick();
        chk_idle("burst_release_idle");

        // ptr now 2: requester 0 wins by wrap-around, then stalls on full.
        req = 4'b0011;
        tick();
        chk_out("stall_beat1", 4'b0001, 1'b1, 8'h11, 2'd0);
        tick();
        chk_out("stall_beat2", 4'b0001, 1'b1, 8'h11, 2'd0);
        fifo_count = 7'd63;
        tick();
        chk_out("stall_full_a", 4'b0000, 1'b0, 8'h11, 2'd0);
        fifo_count = 7'd64;
        tick();
        chk_out("stall_full_b", 4'b0000, 1'b0, 8'h11, 2'd0);
        fifo_count = 7'd62;
        tick();
        chk_out("resume_beat3", 4'b0001, 1'b1, 8'h11, 2'd0);
        tick();
        chk_out("resume_beat4", 4'b0001, 1'b1, 8'h11, 2'd0);
        fifo_count = 7'd0;
        tick();
        chk_out("next_owner_b1", 4'b0010, 1'b1, 8'h22, 2'd1);
        tick();
        chk_out("next_owner_b2", 4'b0010, 1'b1, 8'h22, 2'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("lock_reset", 4'b0000, 1'b0, 8'h00, 2'd0);
        rst_n = 1'b1;
        req = 4'b0010;
        tick();
        chk_out("after_lock_reset", 4'b0010, 1'b1, 8'h22, 2'd1);
        req = 4'b0000;
        tick();
        chk_idle("final_idle");
`else
        tick();
        chk_out("rr_1", 4'b0010, 1'b1, 8'h22, 2'd1);
        tick();
        chk_out("rr_2", 4'b0100, 1'b1, 8'h33, 2'd2);
        tick();
        chk_out("rr_3", 4'b1000, 1'b1, 8'h44, 2'd3);
        tick();
        chk_out("rr_4", 4'b0001, 1'b1, 8'h11, 2'd0);

        req = 4'b0100;
        req_data[23:16] = 8'hA5;
        tick();
        chk_out("single_req2", 4'b0100, 1'b1, 8'hA5, 2'd2);
        req = 4'b0000;
        tick();
        chk_out("req_dropped", 4'b0000, 1'b0, 8'hA5, 2'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle($sformatf("empty_idle%0d", i));
        end

        // Last free slot: one grant, then in-flight write makes free 0.
        fifo_count = 7'd63;
        req = 4'b0001;
        tick();
        chk_out("last_slot", 4'b0001, 1'b1, 8'h11, 2'd0);
        tick();
        chk_out("inflight_full", 4'b0000, 1'b0, 8'h11, 2'd0);
        fifo_count = 7'd64;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_idle($sformatf("full_%0d", i));
        end
        fifo_count = 7'd0;
        tick();
        chk_out("drain_resume", 4'b0001, 1'b1, 8'h11, 2'd0);

        // ptr=1: requester 2 wins; requester 0 drops before being served.
        req = 4'b0101;
        tick();
        chk_out("skip_to_2", 4'b0100, 1'b1, 8'hA5, 2'd2);
        req = 4'b0000;
        tick();
        chk_idle("dropped_req0");
        req = 4'b0011;
        tick();
        chk_out("wrap_to_0", 4'b0001, 1'b1, 8'h11, 2'd0);
        tick();
        chk_out("then_1", 4'b0010, 1'b1, 8'h22, 2'd1);
        req = 4'b0000;
        tick();
        chk_idle("final_idle");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
